t03_nes_poll_sequencer: RTL

T03_NES_POLL_SEQUENCER -- requirements
Module: t03_nes_poll_sequencer

---
 rtl/t03_nes_pkg.sv | 28 ++
 rtl/t03_nes_phase_timer.sv | 36 +++
 rtl/t03_nes_poll_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/t03_nes_pkg.sv
// Shared types and constants for the NES controller poll sequencer.
package t03_nes_pkg;

    localparam int unsigned NES_BITS = 8;

    localparam int unsigned BTN_A      = 7;
    localparam int unsigned BTN_B      = 6;
    localparam int unsigned BTN_SELECT = 5;
    localparam int unsigned BTN_START  = 4;
    localparam int unsigned BTN_UP     = 3;
    localparam int unsigned BTN_DOWN   = 2;
    localparam int unsigned BTN_LEFT   = 1;
    localparam int unsigned BTN_RIGHT  = 0;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE_LO,
        PULSE_HI,
        PULSE_LO
    } nes_state_e;

    // Width for a counter that holds 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/t03_nes_phase_timer.sv
// Loadable down-counter that stops at zero and flags it; used for phase and poll timing.
module t03_nes_phase_timer #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/t03_nes_poll_sequencer.sv
// NES controller poll sequencer: latch/pulse generation, dual-player capture, valid/ready frame output.
// Optional macro T03_NES_EDGE_EN adds p1_pressed/p2_pressed newly-pressed outputs.
module t03_nes_poll_sequencer
    import t03_nes_pkg::*;
#(
    parameter int unsigned LATCH_CYC = 120,
    parameter int unsigned HALF_CYC  = 60,
    parameter int unsigned POLL_CYC  = 166667
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                poll_req,
    input  logic                player_1_in,
    input  logic                player_2_in,
    output logic                latch,
    output logic                pulse,
    output logic                busy,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [NES_BITS-1:0] p1_buttons,
    output logic [NES_BITS-1:0] p2_buttons,
`ifdef T03_NES_EDGE_EN
    output logic                overrun,
    output logic [NES_BITS-1:0] p1_pressed,
    output logic [NES_BITS-1:0] p2_pressed
`else
    output logic                overrun
`endif
);

    localparam int unsigned PH_W = cnt_width((LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC);
    localparam int unsigned PT_W = cnt_width(POLL_CYC);
    localparam logic [2:0]  LAST_PULSE = 3'(NES_BITS - 1);

    nes_state_e          state_q;
    logic [2:0]          pidx_q;
    logic                latch_q;
    logic                pulse_q;
    logic                busy_q;
    logic                fv_q;
    logic                overrun_q;
    logic [NES_BITS-1:0] p1_q;
    logic [NES_BITS-1:0] p2_q;
    // Shadows only need the first seven samples; the eighth goes straight to the outputs.
    logic [NES_BITS-2:0] p1_sh_q;
    logic [NES_BITS-2:0] p2_sh_q;
    logic [NES_BITS-1:0] p1_sh_d;
    logic [NES_BITS-1:0] p2_sh_d;

    logic            poll_zero;
    logic            poll_expire;
    logic            start;
    logic            ph_zero;
    logic            ph_load;
    logic [PH_W-1:0] ph_load_val;
    logic            sample_now;
    logic            publish;

    assign poll_expire = enable & poll_zero;
    assign start       = (state_q == IDLE) && (poll_expire || poll_req);
    assign ph_load     = start || ((state_q != IDLE) && ph_zero);
    assign ph_load_val = start ? PH_W'(LATCH_CYC - 1) : PH_W'(HALF_CYC - 1);
    assign sample_now  = ph_zero && ((state_q == SAMPLE_LO) || (state_q == PULSE_LO));
    assign publish     = ph_zero && (state_q == PULSE_LO) && (pidx_q == LAST_PULSE);

    always_comb begin
        p1_sh_d = {p1_sh_q, ~player_1_in};
        p2_sh_d = {p2_sh_q, ~player_2_in};
    end

    t03_nes_phase_timer #(
        .W       (PT_W),
        .RST_VAL (PT_W'(POLL_CYC - 1))
    ) u_poll_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (poll_expire),
        .load_val_i (PT_W'(POLL_CYC - 1)),
        .en_i       (enable),
        .zero_o     (poll_zero)
    );

    t03_nes_phase_timer #(
        .W       (PH_W),
        .RST_VAL ('0)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ph_load),
        .load_val_i (ph_load_val),
        .en_i       (1'b1),
        .zero_o     (ph_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pidx_q     <= '0;
            latch_q    <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            fv_q       <= 1'b0;
            overrun_q  <= 1'b0;
            p1_q       <= '0;
            p2_q       <= '0;
            p1_sh_q    <= '0;
            p2_sh_q    <= '0;
`ifdef T03_NES_EDGE_EN
            p1_pressed <= '0;
            p2_pressed <= '0;
`endif
        end else begin
            if (sample_now) begin
                p1_sh_q <= p1_sh_d[NES_BITS-2:0];
                p2_sh_q <= p2_sh_d[NES_BITS-2:0];
            end

            if (publish) begin
                p1_q <= p1_sh_d;
                p2_q <= p2_sh_d;
                fv_q <= 1'b1;
                if (fv_q && !frame_ready) begin
                    overrun_q <= 1'b1;
                end
`ifdef T03_NES_EDGE_EN
                p1_pressed <= p1_sh_d & ~p1_q;
                p2_pressed <= p2_sh_d & ~p2_q;
`endif
            end else if (fv_q && frame_ready) begin
                fv_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LATCH;
                        latch_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LATCH: begin
                    if (ph_zero) begin
                        state_q <= SAMPLE_LO;
                        latch_q <= 1'b0;
                    end
                end
                SAMPLE_LO: begin
                    if (ph_zero) begin
                        state_q <= PULSE_HI;
                        pulse_q <= 1'b1;
                        pidx_q  <= 3'd1;
                    end
                end
                PULSE_HI: begin
                    if (ph_zero) begin
                        state_q <= PULSE_LO;
                        pulse_q <= 1'b0;
                    end
                end
                PULSE_LO: begin
                    if (ph_zero) begin
                        if (pidx_q == LAST_PULSE) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= PULSE_HI;
                            pulse_q <= 1'b1;
                            pidx_q  <= pidx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    latch_q <= 1'b0;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign latch       = latch_q;
    assign pulse       = pulse_q;
    assign busy        = busy_q;
    assign frame_valid = fv_q;
    assign overrun     = overrun_q;
    assign p1_buttons  = p1_q;
    assign p2_buttons  = p2_q;

endmodule
